// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: delimits SOF/LEN/payload/XOR frames, buffers the payload,
// holds a checked frame for the decoder until acknowledged, and pulses one error flag per fault.
module uart_rx_frame_ctrl #(
   parameter int unsigned   MAX_LEN        = 16,
   parameter int unsigned   TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]    SOF_BYTE       = 8'hA5,
   localparam int unsigned  ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              frame_valid,
   output logic [7:0]        frame_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   input  logic              frame_ack,
   output logic              busy,
   output logic              err_chk,
   output logic              err_len,
   output logic              err_timeout,
   output logic              err_overrun
);

   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        xor_q, xor_d;
   logic [TO_W-1:0]   tmo_q, tmo_d;
   logic              frame_valid_q, frame_valid_d;
   logic              busy_q, busy_d;
   logic              err_chk_q, err_chk_d;
   logic              err_len_q, err_len_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_overrun_q, err_overrun_d;
   logic              wr_en;
   logic              in_frame;
   logic [7:0]        mem [DEPTH];

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      xor_d         = xor_q;
      tmo_d         = '0;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
      wr_en         = 1'b0;
      in_frame      = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

      if (in_frame && !rx_valid) begin
         tmo_d = tmo_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == SOF_BYTE)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               if ((rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN))) begin
                  len_d   = rx_data;
                  xor_d   = rx_data;
                  cnt_d   = '0;
                  state_d = S_PAYLOAD;
               end else begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               wr_en = 1'b1;
               xor_d = xor_q ^ rx_data;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == (len_q - 8'd1)) begin
                  state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               if (rx_data == xor_q) begin
                  state_d = S_HOLD;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            // Bytes arriving while a frame is held are dropped, even on the ack cycle.
            err_overrun_d = rx_valid;
            if (frame_ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (in_frame && !rx_valid && (tmo_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
         err_timeout_d = 1'b1;
         state_d       = S_IDLE;
      end

      if (state_d == S_IDLE) begin
         cnt_d = '0;
         xor_d = '0;
      end
      if ((state_d == S_IDLE) || (state_d == S_HOLD)) begin
         tmo_d = '0;
      end

      frame_valid_d = (state_d == S_HOLD);
      busy_d        = (state_d == S_LEN) || (state_d == S_PAYLOAD) || (state_d == S_CHK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         xor_q         <= '0;
         tmo_q         <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         xor_q         <= xor_d;
         tmo_q         <= tmo_d;
         frame_valid_q <= frame_valid_d;
         busy_q        <= busy_d;
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[cnt_q[ADDR_W-1:0]] <= rx_data;
      end
   end

   assign rd_data     = mem[rd_addr];
   assign frame_valid = frame_valid_q;
   assign frame_len   = len_q;
   assign busy        = busy_q;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule
